// File: rtl/rfsc_pkg.sv
// Shared types and field widths for the RFSC command issuer:
// the packed command triplet and the issuer state encoding.
package rfsc_pkg;

    localparam int PIN_W   = 3;
    localparam int CIN_W   = 4;
    localparam int SPIN_W  = 3;
    localparam int CMD_W   = PIN_W + CIN_W + SPIN_W;
    localparam int COUNT_W = 8;

    typedef struct packed {
        logic [PIN_W-1:0]  pin;
        logic [CIN_W-1:0]  cin;
        logic [SPIN_W-1:0] spin;
    } rfsc_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_ACK,
        GAP
    } rfsc_issuer_state_e;

endpackage

// File: rtl/rfsc_cmd_issuer_if.sv
// Host-side command channel of the issuer: a valid/ready push of one
// Pin/Cin/SPin triplet. The host is the master, the issuer the slave.
interface rfsc_cmd_issuer_if;
    import rfsc_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [PIN_W-1:0]  cmd_pin;
    logic [CIN_W-1:0]  cmd_cin;
    logic [SPIN_W-1:0] cmd_spin;

    modport master (
        output cmd_valid,
        output cmd_pin,
        output cmd_cin,
        output cmd_spin,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pin,
        input  cmd_cin,
        input  cmd_spin,
        output cmd_ready
    );
endinterface

// File: rtl/rfsc_cmd_fifo.sv
// Small first-word-fall-through FIFO of RFSC commands. Pushes while full
// and pops while empty are dropped; push and pop together keep the level.
module rfsc_cmd_fifo
    import rfsc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  rfsc_cmd_t              data_i,
    input  logic                   pop_i,
    output rfsc_cmd_t              data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    rfsc_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   level_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Storage, pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/rfsc_cmd_issuer.sv
// Command-issuing front end for RFSC_stateNew: queues host commands and
// presents them one at a time with a setup interval, a one-cycle Start/EN
// strobe, an acknowledge wait and an idle gap.
// Optional feature: define RFSC_CMD_TIMEOUT_EN to abandon a command after
// TIMEOUT_CYC cycles without acknowledge and raise the sticky timeout_err.
module rfsc_cmd_issuer
    import rfsc_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 1,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   Clk,
    input  logic                   Reset,
    rfsc_cmd_issuer_if.slave       host,
    output logic                   Start,
    output logic                   EN,
    output logic [PIN_W-1:0]       Pin,
    output logic [CIN_W-1:0]       Cin,
    output logic [SPIN_W-1:0]      SPin,
    input  logic                   update,
    input  logic                   err_clr,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [COUNT_W-1:0]     issued_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam rfsc_issuer_state_e AFTER_CMD = (GAP_CYC == 0) ? IDLE : GAP;

    rfsc_issuer_state_e  state_q;
    logic [CNT_W-1:0]    cnt_q;
    rfsc_cmd_t           cmd_q;
    logic                start_q;
    logic [COUNT_W-1:0]  count_q;

    rfsc_cmd_t           hostCmd;
    rfsc_cmd_t           fifoHead;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                popReq;
    logic                timedOut;

    assign hostCmd = '{pin: host.cmd_pin, cin: host.cmd_cin, spin: host.cmd_spin};
    assign popReq  = (state_q == IDLE) && !fifoEmpty;

    rfsc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (host.cmd_valid),
        .data_i  (hostCmd),
        .pop_i   (popReq),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

`ifdef RFSC_CMD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic timeoutErr_q;

    assign timedOut    = (cnt_q == TIMEOUT_LAST);
    assign timeout_err = timeoutErr_q;

    // Sticky timeout flag; a new timeout beats a clear in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            timeoutErr_q <= 1'b0;
        end else if ((state_q == WAIT_ACK) && !update && timedOut) begin
            timeoutErr_q <= 1'b1;
        end else if (err_clr) begin
            timeoutErr_q <= 1'b0;
        end
    end
`else
    logic        unusedErrClr;
    logic [31:0] unusedTimeoutCyc;

    assign timedOut         = 1'b0;
    assign timeout_err      = 1'b0;
    assign unusedErrClr     = err_clr;
    assign unusedTimeoutCyc = TIMEOUT_CYC;
`endif

    // Issue sequencer: pop, hold setup, strobe once, await ack, then idle gap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            start_q <= 1'b0;
            count_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        cmd_q   <= fifoHead;
                        cnt_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        start_q <= 1'b1;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STROBE: begin
                    cnt_q <= '0;
                    if (update) begin
                        count_q <= count_q + 1'b1;
                        state_q <= AFTER_CMD;
                    end else begin
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (update) begin
                        count_q <= count_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= AFTER_CMD;
                    end else if (timedOut) begin
                        cnt_q   <= '0;
                        state_q <= AFTER_CMD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.cmd_ready = !fifoFull;
    assign busy           = (state_q != IDLE) || !fifoEmpty;
    assign Start          = start_q;
    assign EN             = start_q;
    assign Pin            = cmd_q.pin;
    assign Cin            = cmd_q.cin;
    assign SPin           = cmd_q.spin;
    assign issued_count   = count_q;
endmodule

// File: doc/rfsc_cmd_issuer.md
# rfsc_cmd_issuer

Command-issuing front end for the RFSC state controller. It buffers host commands (Pin/Cin/SPin triplets) in a small FIFO and drives them onto the controller's command interface with a setup interval and a single-cycle Start/EN strobe. It then waits for the controller's `update` acknowledge, with optional timeout. It sits between the host/register logic and `RFSC_stateNew`, whose inputs it drives directly.

## Interface
Reset is synchronous, active-high, on `Reset`; one clock `Clk`.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2
- `SETUP_CYC`, 1: cycles Pin/Cin/SPin are held stable before Start; ≥1
- `GAP_CYC`, 2: idle cycles after each command completes; ≥0
- `TIMEOUT_CYC`, 64: WAIT_ACK cycles before abandoning a command; ≥1

Ports:
- `Clk` in 1: clock
- `Reset` in 1: sync active-high reset
- `cmd_valid` in 1: host command present
- `cmd_ready` out 1: FIFO can accept (= !full)
- `cmd_pin` in 3: port select
- `cmd_cin` in 4: code
- `cmd_spin` in 3: sub-port select
- `Start` out 1: one-cycle command strobe
- `EN` out 1: identical to Start
- `Pin` out 3, `Cin` out 4, `SPin` out 3: registered command to controller
- `update` in 1: controller acknowledge
- `err_clr` in 1: clears `timeout_err`
- `timeout_err` out 1: sticky timeout flag
- `busy` out 1: state≠IDLE or FIFO non-empty
- `issued_count` out 8: acknowledged-command counter
- `fifo_level` out $clog2(DEPTH)+1: entries stored

## Operation
- Push on `cmd_valid && cmd_ready`. No push when full: ready is low, data is held by the host. A simultaneous push and pop when not full is legal; the level is unchanged.
- States:
  - IDLE: if FIFO is non-empty, pop the head into Pin/Cin/SPin and go to SETUP.
  - SETUP: count SETUP_CYC cycles, then go to STROBE.
  - STROBE: Start=EN=1 for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: `update`=1 → issued_count+1, go to GAP. Timeout → timeout_err=1, go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE. GAP_CYC=0 goes straight to IDLE.
- `update` is honoured in STROBE or WAIT_ACK. It is ignored in IDLE/SETUP/GAP.
- Pin/Cin/SPin hold the last command until the next pop. They never change during SETUP/STROBE/WAIT_ACK.
- `issued_count` wraps 255→0. Timed-out commands are not counted.
- `timeout_err` is sticky. `err_clr` clears it. If a timeout and err_clr occur in the same cycle, set wins.
- Commands are issued in strict FIFO order, one at a time.

## Timing
- Reset values: Start=EN=0, Pin=Cin=SPin=0, cmd_ready=1, timeout_err=0, busy=0, issued_count=0, fifo_level=0, state IDLE.
- Reset mid-operation: on the next edge the FIFO is flushed, Start/EN go low, and the in-flight command is dropped and not counted.
- Latency: for a push at edge 0 into an empty idle block:
  - Pin/Cin/SPin are valid after edge 1.
  - Start=EN=1 from edge SETUP_CYC+1 to SETUP_CYC+2.
- The earliest ack is sampled in the STROBE cycle.
- Next-command spacing: the next pop happens GAP_CYC+1 edges after the ack edge.
- Timeout: timeout_err rises TIMEOUT_CYC edges after entering WAIT_ACK.
- All outputs are registered except `cmd_ready`, `busy` and `fifo_level`, which are decoded from registers with no input-to-output path.

## Configuration
- `RFSC_CMD_TIMEOUT_EN` defined: the timeout counter is present and behaves as above.
- Not defined:
  - WAIT_ACK waits indefinitely.
  - `timeout_err` is tied to 0 and `err_clr` is ignored.
  - TIMEOUT_CYC is unused.

## Structure
- Package `rfsc_pkg`:
  - `rfsc_cmd_t` packed struct {pin[2:0], cin[3:0], spin[2:0]}, 10 bits.
  - `rfsc_issuer_state_e` (IDLE, SETUP, STROBE, WAIT_ACK, GAP).
  - Field-width constants.
- Sub-module `rfsc_cmd_fifo`: synchronous FIFO of `rfsc_cmd_t`, parameter DEPTH. Ports: push, pop, full, empty, level. Data is first-word-fall-through.

## Test plan
- Reset: assert Reset for 3 cycles mid-stream → every output at its listed reset value on the next edge; fifo_level=0.
- Single command pin=3, cin=5, spin=1, default parameters, pushed at edge 0; update pulse in the 4th WAIT_ACK cycle → Pin=3/Cin=5/SPin=1 after edge 1; Start=EN=1 only between edges 2–3; issued_count=1; IDLE 3 edges after the ack.
- Burst: push the 7 commands (3,5,1) (3,5,3) (5,5,2) (6,5,5) (4,5,6) (3,5,4) (1,5,7) with cmd_valid held; update pulsed 2 cycles after each Start → cmd_ready low while level=4; all 7 appear on Pin/SPin in order; issued_count=7.
- Timeout (macro defined): one command, update held at 0 → timeout_err=1 at entry+64; issued_count=0. A second queued command is still issued; err_clr clears the flag.
- Reset in WAIT_ACK with 2 queued → Start never rises again; busy=0, fifo_level=0, issued_count=0.
- Spurious ack: update pulses in IDLE and GAP → issued_count unchanged, state unchanged.
